serial_master_port: RTL

Master-side endpoint of the single-wire serial bus. It turns a parallel read or write request from a master module into a bus frame: start, slave ID, address, then write data or read data capture. It checks the slave's acknowledge handshakes and returns read data or an error to the master. There is one instance per bus master, and it drives `data_bus_serial` only while it holds the arbiter grant.

---
 rtl/serial_master_port.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/serial_master_port.sv
// Master endpoint of the single-wire serial bus: frames a parallel request as
// start/ID/address/data, checks slave handshakes and returns read data or an error.
module serial_master_port #(
  parameter int unsigned ADDRESS_WIDTH = 15,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ACK_TIMEOUT   = 16,
  parameter int unsigned RESP_TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req,
  input  logic                     rd_wrt,
  input  logic [2:0]               slave_id,
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     bus_grant,
  output logic                     busy,
  output logic                     bus_util,
  output logic                     done,
  output logic                     timeout_err,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [3:0]               state_wire,
  inout  wire                      data_bus_serial
);

  localparam int unsigned BIT_MAX = (ADDRESS_WIDTH > DATA_WIDTH) ? ADDRESS_WIDTH : DATA_WIDTH;
  localparam int unsigned BIT_W   = $clog2(BIT_MAX + 1);
  localparam int unsigned TO_MAX  = (RESP_TIMEOUT > ACK_TIMEOUT) ? RESP_TIMEOUT : ACK_TIMEOUT;
  localparam int unsigned TO_W    = $clog2(TO_MAX + 1);
  localparam int unsigned SH_W    = DATA_WIDTH - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START1, S_START2, S_TX_ID, S_TX_ADDR, S_WAIT_ADDR_ACK, S_ADDR_ACK2,
    S_TX_MARKER, S_TX_DATA, S_WAIT_DATA_ACK, S_DATA_ACK2, S_WAIT_RD_START,
    S_RX_DATA, S_DONE, S_ERROR
  } state_t;

  state_t                   r_state;
  logic                     r_wr;
  logic [2:0]               r_id;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wdata;
  logic [SH_W-1:0]          r_shift;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [BIT_W-1:0]         r_cnt;
  logic [TO_W-1:0]          r_to;
  logic                     r_busy, r_util, r_done, r_err, r_oe, r_dout;
  wire                      w_line;

  // Drive enable is a reset-cleared flop, so the line releases with rstn.
  assign data_bus_serial = r_oe ? r_dout : 1'bz;
  assign w_line      = data_bus_serial;
  assign busy        = r_busy;
  assign bus_util    = r_util;
  assign done        = r_done;
  assign timeout_err = r_err;
  assign rdata       = r_rdata;
  assign state_wire  = 4'(r_state);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_wr    <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_to    <= '0;
      r_busy  <= 1'b0;
      r_util  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_oe    <= 1'b0;
      r_dout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req && bus_grant) begin
            r_wr    <= rd_wrt;
            r_id    <= slave_id;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_busy  <= 1'b1;
            r_util  <= 1'b1;
            r_oe    <= 1'b1;
            r_dout  <= 1'b0;
            r_state <= S_START1;
          end
        end
        S_START1: r_state <= S_START2;
        S_START2: begin
          r_dout  <= r_id[2];
          r_id    <= {r_id[1:0], 1'b0};
          r_cnt   <= BIT_W'(2);
          r_state <= S_TX_ID;
        end
        S_TX_ID: begin
          if (r_cnt == '0) begin
            r_dout  <= r_addr[ADDRESS_WIDTH-1];
            r_addr  <= {r_addr[ADDRESS_WIDTH-2:0], 1'b0};
            r_cnt   <= BIT_W'(ADDRESS_WIDTH - 1);
            r_state <= S_TX_ADDR;
          end else begin
            r_dout <= r_id[2];
            r_id   <= {r_id[1:0], 1'b0};
            r_cnt  <= r_cnt - BIT_W'(1);
          end
        end
        S_TX_ADDR: begin
          if (r_cnt == '0) begin
            r_oe    <= 1'b0;
            r_to    <= '0;
            r_state <= S_WAIT_ADDR_ACK;
          end else begin
            r_dout <= r_addr[ADDRESS_WIDTH-1];
            r_addr <= {r_addr[ADDRESS_WIDTH-2:0], 1'b0};
            r_cnt  <= r_cnt - BIT_W'(1);
          end
        end
        S_WAIT_ADDR_ACK: begin
          if (!w_line) begin
            r_state <= S_ADDR_ACK2;
          end else if (r_to == TO_W'(ACK_TIMEOUT - 1)) begin
            r_err <= 1'b1; r_busy <= 1'b0; r_util <= 1'b0; r_oe <= 1'b0;
            r_state <= S_ERROR;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_ADDR_ACK2: begin
          if (w_line) begin
            r_err <= 1'b1; r_busy <= 1'b0; r_util <= 1'b0; r_oe <= 1'b0;
            r_state <= S_ERROR;
          end else if (r_wr) begin
            r_oe    <= 1'b1;
            r_dout  <= 1'b1;
            r_state <= S_TX_MARKER;
          end else begin
            r_to    <= '0;
            r_state <= S_WAIT_RD_START;
          end
        end
        S_TX_MARKER: begin
          r_dout  <= r_wdata[DATA_WIDTH-1];
          r_wdata <= {r_wdata[DATA_WIDTH-2:0], 1'b0};
          r_cnt   <= BIT_W'(DATA_WIDTH - 1);
          r_state <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (r_cnt == '0) begin
            r_oe    <= 1'b0;
            r_to    <= '0;
            r_state <= S_WAIT_DATA_ACK;
          end else begin
            r_dout  <= r_wdata[DATA_WIDTH-1];
            r_wdata <= {r_wdata[DATA_WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - BIT_W'(1);
          end
        end
        S_WAIT_DATA_ACK: begin
          if (!w_line) begin
            r_state <= S_DATA_ACK2;
          end else if (r_to == TO_W'(RESP_TIMEOUT - 1)) begin
            r_err <= 1'b1; r_busy <= 1'b0; r_util <= 1'b0; r_oe <= 1'b0;
            r_state <= S_ERROR;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_DATA_ACK2: begin
          r_busy <= 1'b0;
          r_util <= 1'b0;
          if (w_line) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_WAIT_RD_START: begin
          if (!w_line) begin
            r_cnt   <= BIT_W'(DATA_WIDTH - 1);
            r_state <= S_RX_DATA;
          end else if (r_to == TO_W'(RESP_TIMEOUT - 1)) begin
            r_err <= 1'b1; r_busy <= 1'b0; r_util <= 1'b0; r_oe <= 1'b0;
            r_state <= S_ERROR;
          end else begin
            r_to <= r_to + TO_W'(1);
          end
        end
        S_RX_DATA: begin
          r_shift <= SH_W'({r_shift, w_line});
          if (r_cnt == '0) begin
            r_rdata <= {r_shift, w_line};
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_util  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - BIT_W'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERROR: begin
          r_err   <= 1'b0;
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_oe    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
